// File: rtl/element_threshold_binarize_pkg.sv
// hdc_bundling_pkg: shared FSM states and tie-break LFSR constants for the bundling back end
package hdc_bundling_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction
endpackage

// File: rtl/element_threshold_binarize_if.sv
// element_threshold_binarize_if: element input stream, packed word output stream and status
interface element_threshold_binarize_if #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int OUT_WIDTH = 32
);
    logic start;
    logic in_valid;
    logic in_ready;
    logic [ELEMENT_WIDTH-1:0] elem_in;
    logic elem_overflow;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic [OUT_WIDTH-1:0] out_word;
    logic out_last;
    logic overflow;
    logic busy;
    logic done;
    modport master (
        output start, in_valid, elem_in, elem_overflow, in_last, out_ready,
        input in_ready, out_valid, out_word, out_last, overflow, busy, done
    );
    modport slave (
        input start, in_valid, elem_in, elem_overflow, in_last, out_ready,
        output in_ready, out_valid, out_word, out_last, overflow, busy, done
    );
endinterface

// File: rtl/element_threshold_binarize_tie_break_lfsr.sv
// tie_break_lfsr: Galois LFSR whose low bit resolves majority-vote ties, stepping only when asked
module tie_break_lfsr
    import hdc_bundling_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic              bit_out
);
    logic [LFSR_W-1:0] state_q, state_d;
    always_comb begin
        state_d = load ? seed : advance ? lfsr_step(state_q) : state_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_SEED;
        else state_q <= state_d;
    end
    assign bit_out = state_q[0];
endmodule

// File: rtl/element_threshold_binarize.sv
// element_threshold_binarize: sign-thresholds accumulated elements into packed binary words
module element_threshold_binarize
    import hdc_bundling_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input logic clk,
    input logic reset,
    element_threshold_binarize_if.slave bus
);
    localparam int CW = $clog2(OUT_WIDTH);
    state_t state_q, state_d;
    logic [OUT_WIDTH-1:0] pack_q, pack_d, word_q, word_d, merged;
    logic [CW-1:0] cnt_q, cnt_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, ovf_q, ovf_d;
    logic signed [ELEMENT_WIDTH-1:0] e;
    logic start_ok, accept, fire, tie, lfsr_bit, b, word_done, clear;
    always_comb begin
        e = bus.elem_in;
        start_ok = bus.start && (state_q == IDLE || state_q == DONE);
        accept = bus.in_valid && bus.in_ready;
        fire = out_valid_q && bus.out_ready;
        tie = accept && (e == '0);
        // Positive sums vote 1, negative vote 0, zero defers to the LFSR
        b = (e == '0) ? lfsr_bit : !e[ELEMENT_WIDTH-1];
        merged = pack_q | (OUT_WIDTH'(b) << cnt_q);
        word_done = accept && (cnt_q == CW'(OUT_WIDTH - 1) || bus.in_last);
        clear = start_ok || word_done;
        pack_d = clear ? '0 : accept ? merged : pack_q;
        cnt_d = clear ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
        out_valid_d = word_done || (out_valid_q && !bus.out_ready);
        word_d = word_done ? merged : word_q;
        out_last_d = word_done ? bus.in_last : out_last_q;
        ovf_d = !start_ok && (ovf_q || (accept && bus.elem_overflow));
        state_d = start_ok ? COLLECT :
                  (state_q == COLLECT && accept && bus.in_last) ? DRAIN :
                  (state_q == DRAIN && fire && out_last_q) ? DONE : state_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pack_q <= '0;
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            word_q <= '0;
            out_last_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pack_q <= pack_d;
            cnt_q <= cnt_d;
            out_valid_q <= out_valid_d;
            word_q <= word_d;
            out_last_q <= out_last_d;
            ovf_q <= ovf_d;
        end
    end
    tie_break_lfsr #(.RESET_SEED(LFSR_SEED)) u_lfsr (
        .clk(clk),
        .reset(reset),
        .load(start_ok),
        .seed(LFSR_SEED),
        .advance(tie),
        .bit_out(lfsr_bit)
    );
    assign bus.in_ready = (state_q == COLLECT) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_word = word_q;
    assign bus.out_last = out_last_q;
    assign bus.overflow = ovf_q;
    assign bus.busy = (state_q == COLLECT) || (state_q == DRAIN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_element_threshold_binarize.sv
// tb_element_threshold_binarize: directed vectors with hand-computed packed words
module tb_element_threshold_binarize;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] wq[$];
    logic lq[$];
    element_threshold_binarize_if #(.ELEMENT_WIDTH(16), .OUT_WIDTH(8)) bus();
    element_threshold_binarize #(.ELEMENT_WIDTH(16), .OUT_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            wq.push_back(bus.out_word);
            lq.push_back(bus.out_last);
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic send(input int v, input logic ovf, input logic last);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.elem_in = 16'(v);
        bus.elem_overflow = ovf;
        bus.in_last = last;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.elem_overflow = 1'b0;
        bus.in_last = 1'b0;
    endtask
    task automatic wait_done(input string tag);
        int t = 0;
        while (!bus.done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(tag, bus.done, 1);
    endtask
    task automatic pop(input string tag, input logic [7:0] ew, input logic el);
        logic [7:0] w = 8'hxx;
        logic l = 1'bx;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            l = lq.pop_front();
        end
        chk({tag, "_word"}, w, ew);
        chk({tag, "_last"}, l, el);
    endtask
    int t1[8] = '{3, -1, 5, -7, 1, -2, 9, -4};
    int t4[12] = '{1, -1, -1, 1, 1, 1, -1, 1, -1, 2, 0, -3};
    int t6[8] = '{1, 1, -1, -1, 1, -1, 1, -1};
    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.elem_in = '0;
        bus.elem_overflow = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_word", bus.out_word, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_start();
        chk("t1_busy", bus.busy, 1);
        for (int i = 0; i < 8; i++) send(t1[i], 1'b0, i == 7);
        wait_done("t1_done");
        chk("t1_count", wq.size(), 1);
        pop("t1", 8'h55, 1'b1);
        chk("t1_overflow", bus.overflow, 0);
        do_start();
        for (int i = 0; i < 10; i++) send(1, 1'b0, i == 9);
        wait_done("t2_done");
        chk("t2_count", wq.size(), 2);
        pop("t2a", 8'hFF, 1'b0);
        pop("t2b", 8'h03, 1'b1);
        for (int r = 0; r < 2; r++) begin
            do_start();
            for (int i = 0; i < 3; i++) send(0, 1'b0, i == 2);
            wait_done("t3_done");
            chk("t3_count", wq.size(), 1);
            pop("t3", 8'h01, 1'b1);
        end
        bus.out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 8; i++) send(t4[i], 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.elem_in = 16'(t4[8]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", bus.in_ready, 0);
            chk("t4_stall_valid", bus.out_valid, 1);
            chk("t4_stall_word", bus.out_word, 8'hB9);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(t4[i], 1'b0, i == 11);
        wait_done("t4_done");
        chk("t4_count", wq.size(), 2);
        pop("t4a", 8'hB9, 1'b0);
        pop("t4b", 8'h06, 1'b1);
        do_start();
        for (int i = 0; i < 8; i++) begin
            send(1, i == 3, i == 7);
            if (i == 2) chk("t5_ovf_before", bus.overflow, 0);
            if (i == 3) chk("t5_ovf_after", bus.overflow, 1);
        end
        wait_done("t5_done");
        chk("t5_ovf_done", bus.overflow, 1);
        pop("t5", 8'hFF, 1'b1);
        do_start();
        chk("t5_ovf_cleared", bus.overflow, 0);
        for (int i = 0; i < 5; i++) send(1, i == 1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_in_ready", bus.in_ready, 0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_out_word", bus.out_word, 0);
        chk("t6_rst_out_last", bus.out_last, 0);
        chk("t6_rst_overflow", bus.overflow, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_no_partial", wq.size(), 0);
        do_start();
        for (int i = 0; i < 8; i++) send(t6[i], 1'b0, i == 7);
        wait_done("t6_done");
        chk("t6_count", wq.size(), 1);
        pop("t6", 8'h53, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
